// File: rtl/conf_pkg.sv
// rtl/conf_pkg.sv - shared constants and state types for the UART config receiver
package conf_pkg;

   localparam logic [7:0] CH_0     = 8'h30;
   localparam logic [7:0] CH_9     = 8'h39;
   localparam logic [7:0] CH_COMMA = 8'h2C;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_CR    = 8'h0D;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} bit_st_t;

   typedef enum logic {FIELD, DISCARD} prs_st_t;

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= CH_0) && (b <= CH_9);
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - line synchroniser and bit FSM; CONF_PARITY_EN selects 8E1 instead of 8N1
module uart_rx_byte
   import conf_pkg::*;
#(
   parameter int CLK_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_data,
   output logic [7:0] byte_data,
   output logic       byte_vld,
   output logic       byte_err
);

   localparam int CW = $clog2(CLK_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLK_PER_BIT / 2 - 1);

   logic          sync1_q, sync2_q;
   bit_st_t       st_q, st_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic          vld_q, vld_d;
   logic          err_q, err_d;
   logic          stop_ok;
`ifdef CONF_PARITY_EN
   logic          par_bad_q, par_bad_d;
`endif

   logic rx;
   assign rx = sync2_q;

   // two-flop synchroniser; resets to the idle (high) line level
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= uart_data;
         sync2_q <= sync1_q;
      end
   end

   // bit FSM state and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q      <= IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         sh_q      <= '0;
         vld_q     <= 1'b0;
         err_q     <= 1'b0;
`ifdef CONF_PARITY_EN
         par_bad_q <= 1'b0;
`endif
      end else begin
         st_q      <= st_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         sh_q      <= sh_d;
         vld_q     <= vld_d;
         err_q     <= err_d;
`ifdef CONF_PARITY_EN
         par_bad_q <= par_bad_d;
`endif
      end
   end

   // next-state: start is qualified at half bit, later bits sampled every full bit from there
   always_comb begin
      st_d      = st_q;
      cnt_d     = cnt_q + 1'b1;
      bit_d     = bit_q;
      sh_d      = sh_q;
      vld_d     = 1'b0;
      err_d     = 1'b0;
`ifdef CONF_PARITY_EN
      par_bad_d = par_bad_q;
      stop_ok   = rx & ~par_bad_q;
`else
      stop_ok   = rx;
`endif
      case (st_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx) st_d = START;
         end
         START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               bit_d = '0;
               st_d  = rx ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               sh_d  = {rx, sh_q[7:1]};
               bit_d = bit_q + 1'b1;
               if (bit_q == 3'd7) begin
`ifdef CONF_PARITY_EN
                  st_d = PARITY;
`else
                  st_d = STOP;
`endif
               end
            end
         end
`ifdef CONF_PARITY_EN
         PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d     = '0;
               par_bad_d = rx ^ (^sh_q);
               st_d      = STOP;
            end
         end
`endif
         STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (stop_ok) begin
                  vld_d = 1'b1;
                  st_d  = IDLE;
               end else begin
                  err_d = 1'b1;
                  st_d  = BREAK;
               end
            end
         end
         BREAK: begin
            // wait for a full bit time of continuous high line before hunting for a start
            if (!rx) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               st_d  = IDLE;
            end
         end
         default: begin
            st_d  = IDLE;
            cnt_d = '0;
         end
      endcase
   end

   assign byte_data = sh_q;
   assign byte_vld  = vld_q;
   assign byte_err  = err_q;

endmodule

// File: rtl/uart_conf_rx.sv
// rtl/uart_conf_rx.sv - UART decimal-field parameter receiver; CONF_PARITY_EN selects 8E1 frames
module uart_conf_rx
   import conf_pkg::*;
#(
   parameter int CLK_PER_BIT = 16,
   parameter int NUM_PAR     = 5,
   parameter int PAR_W       = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     uart_data,
   output logic [NUM_PAR*PAR_W-1:0] par_flat,
   output logic                     is_data_ready,
   output logic                     rx_err
);

   localparam int IW = (NUM_PAR > 1) ? $clog2(NUM_PAR) : 1;
   localparam int AW = PAR_W + 4;
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_PAR - 1);

   logic [7:0] byte_data;
   logic       byte_vld;
   logic       byte_err;

   uart_rx_byte #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx_byte (
      .clk       (clk),
      .rst       (rst),
      .uart_data (uart_data),
      .byte_data (byte_data),
      .byte_vld  (byte_vld),
      .byte_err  (byte_err)
   );

   prs_st_t                  prs_q, prs_d;
   logic [PAR_W-1:0]         acc_q, acc_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic                     has_digit_q, has_digit_d;
   logic [PAR_W-1:0]         shadow_q [NUM_PAR];
   logic [PAR_W-1:0]         shadow_d [NUM_PAR];
   logic [NUM_PAR*PAR_W-1:0] par_q, par_d;
   logic                     rdy_q, rdy_d;
   logic                     err_q, err_d;

   logic [AW-1:0]            acc_x, prod;
   logic [PAR_W-1:0]         acc_sat;

   // acc*10 + digit with headroom, clamped to all-ones on overflow
   always_comb begin
      acc_x   = AW'(acc_q);
      prod    = (acc_x << 3) + (acc_x << 1) + AW'(byte_data[3:0]);
      acc_sat = (|prod[AW-1:PAR_W]) ? {PAR_W{1'b1}} : prod[PAR_W-1:0];
   end

   // parser registers and committed parameter bank
   always_ff @(posedge clk) begin
      if (rst) begin
         prs_q       <= FIELD;
         acc_q       <= '0;
         idx_q       <= '0;
         has_digit_q <= 1'b0;
         par_q       <= '0;
         rdy_q       <= 1'b0;
         err_q       <= 1'b0;
         for (int i = 0; i < NUM_PAR; i++) shadow_q[i] <= '0;
      end else begin
         prs_q       <= prs_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         has_digit_q <= has_digit_d;
         par_q       <= par_d;
         rdy_q       <= rdy_d;
         err_q       <= err_d;
         shadow_q    <= shadow_d;
      end
   end

   // parser: accumulate digits, stage fields on ',', commit the whole bank atomically on '\n'
   always_comb begin
      prs_d       = prs_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      has_digit_d = has_digit_q;
      shadow_d    = shadow_q;
      par_d       = par_q;
      rdy_d       = 1'b0;
      err_d       = 1'b0;
      case (prs_q)
         FIELD: begin
            if (byte_err) begin
               err_d       = 1'b1;
               prs_d       = DISCARD;
               acc_d       = '0;
               idx_d       = '0;
               has_digit_d = 1'b0;
            end else if (byte_vld) begin
               if (is_digit(byte_data)) begin
                  acc_d       = acc_sat;
                  has_digit_d = 1'b1;
               end else if (byte_data == CH_COMMA) begin
                  if (has_digit_q && (idx_q < IDX_LAST)) begin
                     shadow_d[idx_q] = acc_q;
                     idx_d           = idx_q + 1'b1;
                     acc_d           = '0;
                     has_digit_d     = 1'b0;
                  end else begin
                     err_d       = 1'b1;
                     prs_d       = DISCARD;
                     acc_d       = '0;
                     idx_d       = '0;
                     has_digit_d = 1'b0;
                  end
               end else if (byte_data == CH_LF) begin
                  // the line ends the packet either way, so the parser stays in FIELD
                  if (has_digit_q && (idx_q == IDX_LAST)) begin
                     shadow_d[idx_q] = acc_q;
                     for (int i = 0; i < NUM_PAR; i++) par_d[i*PAR_W +: PAR_W] = shadow_d[i];
                     rdy_d = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
                  acc_d       = '0;
                  idx_d       = '0;
                  has_digit_d = 1'b0;
               end else if (byte_data != CH_CR) begin
                  err_d       = 1'b1;
                  prs_d       = DISCARD;
                  acc_d       = '0;
                  idx_d       = '0;
                  has_digit_d = 1'b0;
               end
            end
         end
         DISCARD: begin
            // one error per packet already reported; resynchronise on the next line end
            if (byte_vld && (byte_data == CH_LF)) prs_d = FIELD;
         end
         default: prs_d = FIELD;
      endcase
   end

   assign par_flat      = par_q;
   assign is_data_ready = rdy_q;
   assign rx_err        = err_q;

endmodule

// File: tb/tb_uart_conf_rx.sv
// tb/tb_uart_conf_rx.sv - scoreboard bench for uart_conf_rx
module tb_uart_conf_rx;

   localparam int CPB = 4;
   localparam int NP  = 5;
   localparam int PW  = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             uart_data;
   logic [NP*PW-1:0] par_flat;
   logic             is_data_ready;
   logic             rx_err;

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct {
      bit               is_err;
      logic [NP*PW-1:0] par;
   } ev_t;

   ev_t exp_q[$];
   logic [NP*PW-1:0] last_par;
`ifdef CONF_PARITY_EN
   bit par_flip = 1'b0;
`endif

   uart_conf_rx #(.CLK_PER_BIT(CPB), .NUM_PAR(NP), .PAR_W(PW)) dut (
      .clk           (clk),
      .rst           (rst),
      .uart_data     (uart_data),
      .par_flat      (par_flat),
      .is_data_ready (is_data_ready),
      .rx_err        (rx_err)
   );

   always #5 clk = ~clk;

   function automatic logic [NP*PW-1:0] mk(input int a, input int b, input int c, input int d, input int e);
      return {16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   task automatic check(input string name, input logic [NP*PW-1:0] act, input logic [NP*PW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic bit_time();
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad_stop, input int hold_low);
      uart_data = 1'b0;
      bit_time();
      for (int i = 0; i < 8; i++) begin
         uart_data = b[i];
         bit_time();
      end
`ifdef CONF_PARITY_EN
      uart_data = (^b) ^ par_flip;
      bit_time();
`endif
      uart_data = ~bad_stop;
      bit_time();
      if (hold_low > 0) begin
         uart_data = 1'b0;
         repeat (hold_low) begin
            @(posedge clk);
            #1;
         end
      end
      uart_data = 1'b1;
      bit_time();
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0, 0);
   endtask

   task automatic push(input bit is_err, input logic [NP*PW-1:0] p);
      ev_t e;
      e.is_err = is_err;
      e.par    = p;
      exp_q.push_back(e);
      if (!is_err) last_par = p;
   endtask

   task automatic settle();
      repeat (4 * CPB) @(posedge clk);
      #1;
   endtask

   // monitor: every output pulse must match the oldest expected event
   always @(negedge clk) begin
      if (!rst && (is_data_ready || rx_err)) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_event: got rdy=%0b err=%0b want no event", is_data_ready, rx_err);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (is_data_ready && rx_err) begin
               n_miss++;
               $display("FAIL event_both: got rdy=1 err=1 want only one");
            end else if (e.is_err != rx_err) begin
               n_miss++;
               $display("FAIL event_kind: got err=%0b want err=%0b", rx_err, e.is_err);
            end else if (!e.is_err && (par_flat !== e.par)) begin
               n_miss++;
               $display("FAIL commit_par: got %h want %h", par_flat, e.par);
            end
         end
      end
   end

   initial begin
      #600000;
      n_vec++;
      n_miss++;
      $display("FAIL watchdog: got timeout want $finish");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      rst       = 1'b1;
      uart_data = 1'b1;
      last_par  = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_par", par_flat, '0);
      check("reset_rdy", {79'd0, is_data_ready}, '0);
      check("reset_err", {79'd0, rx_err}, '0);
      @(posedge clk);
      #1;

      push(1'b0, mk(7, 24, 2, 45, 1));
      send_str("7,24,2,45,1\n");
      settle();

      push(1'b0, mk(16'hFFFF, 1, 1, 1, 1));
      send_str("99999,1,1,1,1\n");
      settle();

      push(1'b1, '0);
      send_str("1,2,3\n");
      settle();
      check("short_keeps_par", par_flat, mk(16'hFFFF, 1, 1, 1, 1));
      push(1'b0, mk(5, 5, 5, 5, 5));
      send_str("5,5,5,5,5\n");
      settle();

      push(1'b1, '0);
      send_str("1,,3,4,5\n");
      push(1'b1, '0);
      send_str("1,2,3,4,5,6\n");
      push(1'b1, '0);
      send_str("1,2x,3,4,5\n");
      settle();
      check("bad_keeps_par", par_flat, mk(5, 5, 5, 5, 5));
      push(1'b0, mk(9, 8, 7, 6, 5));
      send_str("9,8,7,6,5\n");
      settle();

      push(1'b1, '0);
      send_str("1,2");
      send_byte("3", 1'b1, 40);
      repeat (3) bit_time();
      send_str("\n");
      settle();
      check("break_keeps_par", par_flat, mk(9, 8, 7, 6, 5));
      uart_data = 1'b0;
      @(posedge clk);
      #1;
      uart_data = 1'b1;
      repeat (4) bit_time();
      check("glitch_keeps_par", par_flat, mk(9, 8, 7, 6, 5));
      push(1'b0, mk(1, 2, 3, 4, 5));
      send_str("1,2,3,4,5\n");
      settle();

      send_str("3,4,");
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_clears_par", par_flat, '0);
      @(posedge clk);
      #1;
      push(1'b0, mk(1, 1, 1, 1, 1));
      send_str("1,1,1,1,1\n");
      settle();

`ifdef CONF_PARITY_EN
      push(1'b1, '0);
      send_str("1,2,");
      par_flip = 1'b1;
      send_byte("3", 1'b0, 0);
      par_flip = 1'b0;
      send_str(",4,5\n");
      settle();
      check("parity_keeps_par", par_flat, mk(1, 1, 1, 1, 1));
      push(1'b0, mk(2, 2, 2, 2, 2));
      send_str("2,2,2,2,2\n");
      settle();
`endif

      check("final_par", par_flat, last_par);
      check("drain", 80'(exp_q.size()), '0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
